// File: rtl/fifo_dp_sync.sv
// ============================================================================
//  fifo_dp_sync : single-clock first-word-fall-through FIFO on simple dual-port RAM
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module fifo_dp_sync #(
  parameter int WIDTH       = 9,
  parameter int ADDR_W      = 9,
  parameter int AFULL_LEVEL = (1 << ADDR_W) - 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] PIPE_CAP = {{(ADDR_W-1){1'b0}}, 2'd2};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  ram_rdata_q;

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ram_vld_q, ram_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0]  skid_data_q, skid_data_d;
  logic              out_vld_q, out_vld_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              push, pop, issue;
  logic [ADDR_W:0]   pipe_cnt, ram_words;

  always_comb begin
    push      = wr_en && !full && !flush;
    pop       = rd_en && out_vld_q && !flush;
    pipe_cnt  = {{ADDR_W{1'b0}}, out_vld_q} + {{ADDR_W{1'b0}}, skid_vld_q}
              + {{ADDR_W{1'b0}}, ram_vld_q};
    ram_words = count_q - pipe_cnt;
    // Read ahead only if the word can still land in out/skid once it arrives.
    issue     = !flush && (ram_words != '0)
              && ((pipe_cnt - {{ADDR_W{1'b0}}, pop}) < PIPE_CAP);

    wptr_d      = push  ? wptr_q + PTR_ONE : wptr_q;
    rptr_d      = issue ? rptr_q + PTR_ONE : rptr_q;
    ram_vld_d   = issue;
    count_d     = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    overflow_d  = wr_en && full && !flush;
    underflow_d = rd_en && !out_vld_q && !flush;

    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;

    // Oldest-first compaction of {out, skid, ram register} into {out, skid}.
    if (out_vld_q && !pop) begin
      if (!skid_vld_q && ram_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_data_d = ram_rdata_q;
      end
    end else if (skid_vld_q) begin
      out_vld_d   = 1'b1;
      out_data_d  = skid_data_q;
      skid_vld_d  = ram_vld_q;
      skid_data_d = ram_rdata_q;
    end else begin
      out_vld_d = ram_vld_q;
      if (ram_vld_q) begin
        out_data_d = ram_rdata_q;
      end
    end

    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      ram_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= wr_data;
    end
    if (issue) begin
      ram_rdata_q <= mem[rptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ram_vld_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ram_vld_q   <= ram_vld_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AFULL_C);
  assign count       = count_q;
  assign rd_valid    = out_vld_q;
  assign rd_data     = out_data_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_dp_sync.sv
// ============================================================================
//  tb_fifo_dp_sync : randomized self-checking bench for fifo_dp_sync (16 x 9)
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_dp_sync;

  localparam int WIDTH  = 9;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [ADDR_W:0]  count;
  logic             overflow;
  logic             underflow;

  always #5 clk = ~clk;

  fifo_dp_sync #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_LEVEL(AFULL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // Reference: each held word remembers the edge that accepted it; the head
  // is visible once it has been held for two edges.
  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
  } ent_t;

  ent_t q[$];
  int   cyc     = 0;
  int   n_err   = 0;
  int   n_check = 0;
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_valid();
    return (q.size() > 0) && ((cyc - q[0].t) >= 2);
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = model_valid();
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
    check("rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) check("rd_data", 32'(rd_data), 32'(q[0].d));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_unf));
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_count"}, 32'(count), 32'd0);
    check({pfx, "_full"}, 32'(full), 32'd0);
    check({pfx, "_afull"}, 32'(almost_full), 32'd0);
    check({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({pfx, "_rd_data"}, 32'(rd_data), 32'd0);
    check({pfx, "_overflow"}, 32'(overflow), 32'd0);
    check({pfx, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re, input logic fl);
    logic fm, vm;
    fm      = (q.size() == DEPTH);
    vm      = model_valid();
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    @(posedge clk);
    #1;
    cyc++;
    exp_ovf = we && fm && !fl;
    exp_unf = re && !vm && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (re && vm) void'(q.pop_front());
      if (we && !fm) q.push_back('{d: wd, t: cyc});
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() > 0; k++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(count), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    #12;
    check_reset_values("reset");
    #4;
    reset_n = 1'b1;

    // Fill to full, then one rejected push.
    for (int i = 0; i < 16; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
    step(1'b1, 9'h1FF, 1'b0, 1'b0);

    // Drain with rd_en held: 16 pops then an underflow.
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Single push latency.
    step(1'b1, 9'h1A5, 1'b0, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b0);

    // Streaming with three words queued, crossing the pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 9'($urandom()), 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 100; i++) step(1'b1, 9'($urandom()), 1'b1, 1'b0);
    drain();

    // Full FIFO with push and pop on the same edge.
    for (int k = 0; k < 20 && q.size() < DEPTH; k++) step(1'b1, 9'($urandom()), 1'b0, 1'b0);
    idle(2);
    step(1'b1, 9'h0AA, 1'b1, 1'b0);
    drain();

    // Flush with 7 words held and both requests active.
    for (int i = 0; i < 7; i++) step(1'b1, 9'($urandom()), 1'b0, 1'b0);
    idle(2);
    step(1'b1, 9'h1EE, 1'b1, 1'b1);
    step(1'b1, 9'h055, 1'b0, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic at several push/pop densities.
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 55 : 95;
      pr = (ph == 0) ? 40 : (ph == 1) ? 85 : (ph == 2) ? 55 : 70;
      for (int i = 0; i < 120; i++) begin
        step($urandom_range(0, 99) < pw, 9'($urandom()),
             $urandom_range(0, 99) < pr, $urandom_range(0, 63) == 0);
      end
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 10; i++) step(1'b1, 9'($urandom()), (i > 4), 1'b0);
    step(1'b1, 9'($urandom()), 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("held_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step($urandom_range(0, 99) < 60, 9'($urandom()), $urandom_range(0, 99) < 50, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_check);
    $finish;
  end

endmodule

`default_nettype wire
